sample_capture: RTL and testbench
=================================

# sample_capture

Acquisition front end that fills the 256-byte sample memory drained by the UART readout stage. After an `arm` pulse it watches the ADC sample stream for a level crossing, or forces a trigger after a timeout. It then writes 256 consecutive samples, optionally decimated, to addresses 0..255 and pulses `done`. The readout stage is activated from `done` and reads the buffer back from address 0.

## Interface
- `DATA_W`, default 8: sample and memory data width.
- `ADDR_W`, default 8: memory address width; buffer depth is 2^ADDR_W.
- `AUTO_TIMEOUT`, default 5000000: cycles spent in WAIT_TRIG before an auto trigger (0.1 s at 50 MHz).

- `clk_50mhz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `arm`  in  1  start a capture; honoured only in IDLE.
- `abort`  in  1  cancel the capture; highest priority.
- `adc_data`  in  DATA_W  sample value, unsigned.
- `adc_valid`  in  1  `adc_data` is valid this cycle.
- `trig_level`  in  DATA_W  trigger threshold; latched on arm.
- `trig_edge`  in  1  0 = rising, 1 = falling; latched on arm.
- `trig_auto`  in  1  enable the timeout trigger; latched on arm.
- `decim`  in  8  keep 1 of every decim+1 samples after the trigger; latched on arm.
- `mem_we`  out  1  write strobe, one cycle per sample.
- `mem_waddr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `busy`  out  1  high in WAIT_TRIG and CAPTURE.
- `triggered`  out  1  high from the trigger until the next arm.
- `done`  out  1  one-cycle pulse after the last write.

## Operation
- States:
  - IDLE, WAIT_TRIG, CAPTURE, DONE.
  - Any other encoding goes to IDLE.
- IDLE:
  - `arm`=1 latches `trig_level`, `trig_edge`, `trig_auto` and `decim`.
  - It also clears `triggered`, the previous-sample valid flag and the timeout counter, then enters WAIT_TRIG.
- WAIT_TRIG:
  - Each `adc_valid` sample is compared with the stored previous sample `prev`.
  - Rising trigger: `prev` < level and `cur` >= level.
  - Falling trigger: `prev` >= level and `cur` < level.
  - The first valid sample after arm only loads `prev`; it can never trigger.
  - On a trigger: write `cur` to address 0, set `triggered`, clear the decimation counter and enter CAPTURE.
  - The timeout counter (23 bits) increments every cycle in WAIT_TRIG.
  - If `trig_auto`=1 and the counter equals AUTO_TIMEOUT-1 with no level trigger that cycle:
    - set `triggered` and enter CAPTURE with the "next valid sample writes" flag set;
    - that next sample goes to address 0.
  - If `trig_auto`=0, WAIT_TRIG lasts until a trigger or `abort`.
- CAPTURE, per valid sample:
  - If the write flag is set or `dcnt` == `decim`: write at the next address, clear `dcnt`, clear the flag.
  - Otherwise: `dcnt`++.
- The write address increments by 1 after each write and never wraps during a capture.
- The write to address 2^ADDR_W-1 ends CAPTURE and enters DONE.
- DONE:
  - `done`=1 for one cycle, then IDLE.
  - `mem_waddr` returns to 0 and `triggered` stays 1.
- `abort`:
  - In any state it moves to IDLE next cycle, with no `done` and no further `mem_we`.
  - `abort` and `arm` in the same cycle: `abort` wins and the arm is dropped.
- `arm` while busy or in DONE is ignored.
- Invalid cycles (`adc_valid`=0) change no comparison, counter or address state; only the timeout counter advances.

## Timing
- Reset values:
  - `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `busy`=0, `triggered`=0, `done`=0, state IDLE.
  - `prev`, `dcnt` and the timeout counter are also 0.
- Reset is asynchronous; deasserting it mid-capture leaves the block in IDLE, with partial memory contents left as they are.
- All outputs are registered.
- An `adc_valid` sample in cycle N that is written produces `mem_we`=1 in cycle N+1, with that sample on `mem_wdata` and its address on `mem_waddr`.
- `arm` in cycle N gives `busy`=1 in cycle N+1.
- The last write (address 255) appears in cycle M, `done` in cycle M+1, and `busy`=0 from cycle M+1.
- Trigger and last sample never coincide: at least 256 valid samples after the trigger are needed.
- With `decim`=D and continuous `adc_valid`, samples are written every D+1 cycles.

## Test plan
- Rising trigger, `decim`=0:
  - Stimulus: level 0x80, ramp 0x00,0x01,… with `adc_valid` every cycle.
  - Required: first write is addr 0 = 0x80 one cycle after 0x80 is presented, addresses 0..255 hold 0x80..0x7F (mod 256), and `done` pulses exactly once, the cycle after addr 255.
- Falling trigger, `decim`=3:
  - Stimulus: level 0x40, descending ramp from 0xFF.
  - Required: addr 0 = 0x3F, addr 1 = 0x3B, addr k = 0x3F-4k (mod 256).
- First-sample rule:
  - Stimulus: first valid sample after arm is 0x90 with level 0x80 rising, then 0x70, 0x85.
  - Required: no trigger on 0x90; trigger on 0x85, which is written at addr 0.
- Auto trigger:
  - Stimulus: `trig_auto`=1, `AUTO_TIMEOUT`=100 (bench override), constant 0x10.
  - Required: `triggered` goes high 100 cycles after `busy` rises, the next valid sample is written at addr 0, and `done` follows 256 writes.
  - With `trig_auto`=0 and the same stimulus, no write occurs within 10000 cycles.
- Abort:
  - Stimulus: `abort` in CAPTURE after 50 writes.
  - Required: IDLE next cycle, no further `mem_we`, no `done`.
  - A later `arm` restarts the capture from addr 0.
  - `abort` and `arm` together in IDLE leave `busy`=0.
- Reset mid-capture and re-arm while busy:
  - Stimulus: assert `reset` low asynchronously mid-capture.
  - Required: all outputs read 0 immediately.
  - An `arm` pulse during CAPTURE has no effect on addresses or `done`.

Source files
------------

// File: rtl/sample_capture.sv
`timescale 1ns/1ps
// Armed acquisition front end: waits for a level crossing or a timeout, then fills a
// 2^ADDR_W-entry sample buffer with optionally decimated ADC samples and pulses done.
module sample_capture #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int AUTO_TIMEOUT = 5000000
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              trig_auto,
  input  logic [7:0]        decim,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam logic [22:0] TMO_LAST = 23'(AUTO_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] lvl_r;
  logic [DATA_W-1:0] prev;
  logic              edge_r;
  logic              auto_r;
  logic              prev_vld;
  logic              wr_next;
  logic [7:0]        decim_r;
  logic [7:0]        dcnt;
  logic [22:0]       tcnt;
  logic [ADDR_W-1:0] wptr;

  // Level crossing between two consecutive valid samples; fall selects the falling edge.
  function automatic logic crossed(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] c,
                                   input logic [DATA_W-1:0] lvl, input logic fall);
    if (fall)
      return (p >= lvl) && (c < lvl);
    return (p < lvl) && (c >= lvl);
  endfunction

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lvl_r     <= '0;
      prev      <= '0;
      edge_r    <= 1'b0;
      auto_r    <= 1'b0;
      prev_vld  <= 1'b0;
      wr_next   <= 1'b0;
      decim_r   <= '0;
      dcnt      <= '0;
      tcnt      <= '0;
      wptr      <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        wr_next   <= 1'b0;
        mem_waddr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              lvl_r     <= trig_level;
              edge_r    <= trig_edge;
              auto_r    <= trig_auto;
              decim_r   <= decim;
              triggered <= 1'b0;
              prev_vld  <= 1'b0;
              tcnt      <= '0;
              busy      <= 1'b1;
              state     <= WAIT_TRIG;
            end
          end
          WAIT_TRIG: begin
            tcnt <= tcnt + 23'd1;
            if (adc_valid && prev_vld && crossed(prev, adc_data, lvl_r, edge_r)) begin
              mem_we    <= 1'b1;
              mem_waddr <= '0;
              mem_wdata <= adc_data;
              wptr      <= ADDR_W'(1);
              dcnt      <= '0;
              triggered <= 1'b1;
              state     <= CAPTURE;
            end else if (auto_r && tcnt == TMO_LAST) begin
              // Timeout: the next valid sample becomes the first buffer entry.
              wptr      <= '0;
              dcnt      <= '0;
              wr_next   <= 1'b1;
              triggered <= 1'b1;
              state     <= CAPTURE;
            end
            if (adc_valid) begin
              prev     <= adc_data;
              prev_vld <= 1'b1;
            end
          end
          CAPTURE: begin
            if (adc_valid) begin
              if (wr_next || dcnt == decim_r) begin
                mem_we    <= 1'b1;
                mem_waddr <= wptr;
                mem_wdata <= adc_data;
                wptr      <= wptr + ADDR_W'(1);
                dcnt      <= '0;
                wr_next   <= 1'b0;
                if (wptr == '1)
                  state <= DONE;
              end else begin
                dcnt <= dcnt + 8'd1;
              end
            end
          end
          DONE: begin
            done      <= 1'b1;
            busy      <= 1'b0;
            mem_waddr <= '0;
            state     <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
`timescale 1ns/1ps
// Bench for sample_capture: table-driven level-trigger captures, hand-written corner
// sequences and randomized captures, all compared against a queue-based reference model.
module tb_sample_capture;

  localparam int TMO = 100;

  logic       clk_50mhz = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       adc_valid = 1'b0;
  logic       trig_edge = 1'b0;
  logic       trig_auto = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic [7:0] trig_level = 8'h00;
  logic [7:0] decim = 8'h00;
  logic       mem_we, busy, triggered, done;
  logic [7:0] mem_waddr, mem_wdata;

  always #10 clk_50mhz = ~clk_50mhz;

  sample_capture #(.DATA_W(8), .ADDR_W(8), .AUTO_TIMEOUT(TMO)) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .arm       (arm),
    .abort     (abort),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .trig_level(trig_level),
    .trig_edge (trig_edge),
    .trig_auto (trig_auto),
    .decim     (decim),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .triggered (triggered),
    .done      (done)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk_50mhz) cyc <= cyc + 1;

  logic [7:0] s_q[$];
  bit         v_q[$];
  int         drv_q[$];
  bit         trg_q[$];
  int         wa_q[$], wd_q[$], wc_q[$], dn_q[$];
  int         exp_d[$], exp_i[$];
  int         trig_at;

  always @(negedge clk_50mhz) begin
    if (mem_we) begin
      wa_q.push_back(int'(mem_waddr));
      wd_q.push_back(int'(mem_wdata));
      wc_q.push_back(cyc);
    end
    if (done) dn_q.push_back(cyc);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Expected buffer contents: trigger on the first crossing between consecutive valid
  // samples, then keep every (d+1)-th valid sample until 256 entries are written.
  task automatic model(input logic [7:0] lvl, input bit edg, input bit aut, input int d);
    bit         have_p, cap, pend;
    logic [7:0] p;
    int         k;
    have_p = 0; cap = 0; pend = 0; p = 8'h00; k = 0;
    exp_d.delete(); exp_i.delete(); trig_at = -1;
    for (int i = 0; i < s_q.size(); i++) begin
      if (!cap) begin
        if (v_q[i]) begin
          if (have_p && (edg ? (p >= lvl && s_q[i] < lvl) : (p < lvl && s_q[i] >= lvl))) begin
            cap = 1; trig_at = i; k = 0;
            exp_d.push_back(int'(s_q[i])); exp_i.push_back(i);
          end
          p = s_q[i]; have_p = 1;
        end
        if (!cap && aut && i == TMO - 1) begin
          cap = 1; pend = 1; trig_at = i;
        end
      end else if (v_q[i] && exp_d.size() < 256) begin
        if (pend) begin
          pend = 0; k = 0;
          exp_d.push_back(int'(s_q[i])); exp_i.push_back(i);
        end else begin
          k++;
          if (k % (d + 1) == 0) begin
            exp_d.push_back(int'(s_q[i])); exp_i.push_back(i);
          end
        end
      end
    end
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); dn_q.delete();
    drv_q.delete(); trg_q.delete();
  endtask

  task automatic run(input string tag, input logic [7:0] lvl, input bit edg, input bit aut,
                     input logic [7:0] d, input int arm_at);
    bit got_done;
    int busy_d, waddr_d, nw;
    got_done = 0; busy_d = -1; waddr_d = -1;
    clear_logs();
    trig_level = lvl; trig_edge = edg; trig_auto = aut; decim = d; arm = 1'b1;
    @(negedge clk_50mhz);
    arm = 1'b0;
    chk({tag, ".busy_after_arm"}, int'(busy), 1);
    for (int i = 0; i < s_q.size(); i++) begin
      trg_q.push_back(triggered);
      if (done) begin
        got_done = 1; busy_d = int'(busy); waddr_d = int'(mem_waddr);
        break;
      end
      adc_data = s_q[i]; adc_valid = v_q[i]; arm = (i == arm_at);
      drv_q.push_back(cyc);
      @(negedge clk_50mhz);
    end
    adc_valid = 1'b0; arm = 1'b0;
    for (int w = 0; w < 20 && !got_done; w++) begin
      if (done) begin
        got_done = 1; busy_d = int'(busy); waddr_d = int'(mem_waddr);
      end else begin
        @(negedge clk_50mhz);
      end
    end
    repeat (3) @(negedge clk_50mhz);
    model(lvl, edg, aut, int'(d));
    chk({tag, ".done_seen"}, int'(got_done), 1);
    chk({tag, ".write_count"}, wa_q.size(), exp_d.size());
    nw = (wa_q.size() < exp_d.size()) ? wa_q.size() : exp_d.size();
    for (int k = 0; k < nw; k++) begin
      chk({tag, ".addr"}, wa_q[k], k);
      chk({tag, ".data"}, wd_q[k], exp_d[k]);
      if (exp_i[k] < drv_q.size())
        chk({tag, ".write_cycle"}, wc_q[k], drv_q[exp_i[k]] + 1);
    end
    chk({tag, ".done_pulses"}, dn_q.size(), 1);
    if (dn_q.size() > 0 && wc_q.size() > 0)
      chk({tag, ".done_cycle"}, dn_q[0], wc_q[wc_q.size() - 1] + 1);
    if (got_done) begin
      chk({tag, ".busy_at_done"}, busy_d, 0);
      chk({tag, ".waddr_at_done"}, waddr_d, 0);
    end
    if (trig_at >= 0 && trig_at + 1 < trg_q.size()) begin
      chk({tag, ".trig_before"}, int'(trg_q[trig_at]), 0);
      chk({tag, ".trig_after"}, int'(trg_q[trig_at + 1]), 1);
    end
    if (!got_done) begin
      abort = 1'b1;
      @(negedge clk_50mhz);
      abort = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] lvl;
    bit         edg;
    logic [7:0] d;
    logic [7:0] start;
    int         step;
    int         arm_at;
    int         e0, e1, e255;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{8'h80, 1'b0, 8'd0, 8'h00,  1, 200, 'h80, 'h81, 'h7F};
    tbl[1] = '{8'h40, 1'b1, 8'd3, 8'hFF, -1,  -1, 'h3F, 'h3B, 'h43};
    tbl[2] = '{8'h10, 1'b0, 8'd1, 8'h00,  2,  -1, 'h10, 'h14, 'h0C};
    tbl[3] = '{8'hC0, 1'b1, 8'd0, 8'hFF, -3,  -1, 'hBD, 'hBA, 'hC0};

    // Reset state
    @(negedge clk_50mhz);
    chk("rst.mem_we", int'(mem_we), 0);
    chk("rst.mem_waddr", int'(mem_waddr), 0);
    chk("rst.mem_wdata", int'(mem_wdata), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.triggered", int'(triggered), 0);
    chk("rst.done", int'(done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk_50mhz);

    // Table of ramp captures
    for (int t = 0; t < 4; t++) begin
      s_q.delete(); v_q.delete();
      for (int i = 0; i < 300 + 256 * (int'(tbl[t].d) + 1); i++) begin
        s_q.push_back(8'(int'(tbl[t].start) + tbl[t].step * i));
        v_q.push_back(1'b1);
      end
      run($sformatf("tbl%0d", t), tbl[t].lvl, tbl[t].edg, 1'b0, tbl[t].d, tbl[t].arm_at);
      if (wd_q.size() == 256) begin
        chk($sformatf("tbl%0d.addr0", t), wd_q[0], tbl[t].e0);
        chk($sformatf("tbl%0d.addr1", t), wd_q[1], tbl[t].e1);
        chk($sformatf("tbl%0d.addr255", t), wd_q[255], tbl[t].e255);
      end else begin
        chk($sformatf("tbl%0d.buffer_full", t), wd_q.size(), 256);
      end
    end

    // First valid sample after arm only loads the previous sample
    s_q.delete(); v_q.delete();
    s_q.push_back(8'h90); s_q.push_back(8'h70); s_q.push_back(8'h85);
    for (int i = 0; i < 300; i++) s_q.push_back(8'(8'h86 + i));
    for (int i = 0; i < s_q.size(); i++) v_q.push_back(1'b1);
    run("first", 8'h80, 1'b0, 1'b0, 8'd0, -1);
    if (wd_q.size() > 0 && trg_q.size() > 2 && drv_q.size() > 2) begin
      chk("first.no_trig_on_0x90", int'(trg_q[1]), 0);
      chk("first.addr0", wd_q[0], 'h85);
      chk("first.addr0_cycle", wc_q[0] - drv_q[2], 1);
    end else begin
      chk("first.any_write", wd_q.size(), 256);
    end

    // Auto trigger after the timeout
    s_q.delete(); v_q.delete();
    for (int i = 0; i < TMO + 300; i++) begin
      s_q.push_back(8'h10); v_q.push_back(1'b1);
    end
    run("auto", 8'h80, 1'b0, 1'b1, 8'd0, -1);
    if (trg_q.size() > TMO && drv_q.size() > TMO && wc_q.size() > 0) begin
      chk("auto.trig_low_at_99", int'(trg_q[TMO - 1]), 0);
      chk("auto.trig_high_at_100", int'(trg_q[TMO]), 1);
      chk("auto.first_write_cycle", wc_q[0] - drv_q[0], TMO + 1);
    end else begin
      chk("auto.any_write", wc_q.size(), 256);
    end

    // No timeout trigger when disabled
    clear_logs();
    trig_level = 8'h80; trig_edge = 1'b0; trig_auto = 1'b0; decim = 8'd0; arm = 1'b1;
    @(negedge clk_50mhz);
    arm = 1'b0; adc_data = 8'h10; adc_valid = 1'b1;
    repeat (10000) @(negedge clk_50mhz);
    chk("noauto.writes", wa_q.size(), 0);
    chk("noauto.busy", int'(busy), 1);
    chk("noauto.triggered", int'(triggered), 0);
    abort = 1'b1;
    @(negedge clk_50mhz);
    abort = 1'b0; adc_valid = 1'b0;
    chk("noauto.abort_busy", int'(busy), 0);

    // Abort during capture after 50 writes
    begin
      bit hit;
      hit = 0;
      clear_logs();
      trig_level = 8'h80; trig_edge = 1'b0; trig_auto = 1'b0; decim = 8'd0; arm = 1'b1;
      @(negedge clk_50mhz);
      arm = 1'b0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        if (mem_we && mem_waddr == 8'd49) hit = 1;
        if (hit) abort = 1'b1;
        adc_data = 8'(i); adc_valid = 1'b1;
        @(negedge clk_50mhz);
      end
      abort = 1'b0;
      chk("abort.reached_50", int'(hit), 1);
      chk("abort.busy_next", int'(busy), 0);
      chk("abort.we_next", int'(mem_we), 0);
      for (int i = 0; i < 300; i++) begin
        adc_data = 8'(i); @(negedge clk_50mhz);
      end
      adc_valid = 1'b0;
      chk("abort.total_writes", wa_q.size(), 50);
      chk("abort.no_done", dn_q.size(), 0);
    end

    // Re-arm after abort restarts from address 0
    s_q.delete(); v_q.delete();
    for (int i = 0; i < 600; i++) begin
      s_q.push_back(8'(i)); v_q.push_back(1'b1);
    end
    run("rearm", 8'h80, 1'b0, 1'b0, 8'd0, -1);

    // abort and arm together in IDLE
    arm = 1'b1; abort = 1'b1;
    @(negedge clk_50mhz);
    arm = 1'b0; abort = 1'b0;
    chk("armabort.busy", int'(busy), 0);
    @(negedge clk_50mhz);
    chk("armabort.busy_later", int'(busy), 0);

    // Asynchronous reset mid-capture
    begin
      bit hit;
      int nw;
      hit = 0;
      clear_logs();
      trig_level = 8'h80; trig_edge = 1'b0; trig_auto = 1'b0; decim = 8'd0; arm = 1'b1;
      @(negedge clk_50mhz);
      arm = 1'b0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        if (mem_we && mem_waddr == 8'd20) hit = 1;
        else begin
          adc_data = 8'(i); adc_valid = 1'b1;
          @(negedge clk_50mhz);
        end
      end
      chk("rstmid.reached_20", int'(hit), 1);
      #3 reset = 1'b0;
      #1;
      chk("rstmid.mem_we", int'(mem_we), 0);
      chk("rstmid.mem_waddr", int'(mem_waddr), 0);
      chk("rstmid.mem_wdata", int'(mem_wdata), 0);
      chk("rstmid.busy", int'(busy), 0);
      chk("rstmid.triggered", int'(triggered), 0);
      chk("rstmid.done", int'(done), 0);
      @(negedge clk_50mhz);
      reset = 1'b1;
      nw = wa_q.size();
      for (int i = 0; i < 300; i++) begin
        adc_data = 8'(i); @(negedge clk_50mhz);
      end
      adc_valid = 1'b0;
      chk("rstmid.idle_busy", int'(busy), 0);
      chk("rstmid.no_writes_after", wa_q.size(), nw);
    end

    // Randomized captures with sparse adc_valid
    for (int r = 0; r < 4; r++) begin
      logic [7:0] lvl, d;
      bit         edg;
      lvl = 8'($urandom_range(8'h20, 8'hE0));
      edg = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 3));
      s_q.delete(); v_q.delete();
      for (int i = 0; i < 200 + 2 * 256 * (int'(d) + 1); i++) begin
        s_q.push_back(8'($urandom));
        v_q.push_back($urandom_range(0, 3) != 0);
      end
      run($sformatf("rand%0d", r), lvl, edg, 1'b0, d, (r == 1) ? 400 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
